router_port_rx: RTL
===================

// Module: router_port_rx
// PURPOSE
// Receive-side endpoint for one router output port: deserialises the LSB-first bit stream
// on dout/valido_n/frameo_n into bytes, tags the final byte of each packet, and buffers
// them in a first-word-fall-through FIFO with a valid/ready read interface. One instance
// per router output port, between the router and the packet consumer.
// PARAMETERS
// FIFO_DEPTH  16  byte entries in the receive FIFO (power of 2, >= 2)
// CNT_W       16  width of the completed-packet counter
// PORTS
// clock       in   1            system clock, all logic on rising edge
// reset_n     in   1            asynchronous, active-low reset
// dout        in   1            serial data from router output port, LSB first
// valido_n    in   1            active-low: dout carries a valid bit this cycle
// frameo_n    in   1            active-low frame; high on an accepted bit marks last bit
// rx_valid    out  1            FIFO head holds a byte
// rx_ready    in   1            consumer accepts head when rx_valid && rx_ready
// rx_data     out  8            head byte
// rx_last     out  1            head byte is the final byte of its packet
// pkt_cnt     out  CNT_W        packets fully written to FIFO, wraps modulo 2**CNT_W
// frag_err    out  1            sticky: a packet ended on a non-byte boundary
// ovf_err     out  1            sticky: a byte was dropped because the FIFO was full
// err_clr     in   1            synchronous clear of frag_err and ovf_err
// BEHAVIOUR
// Reset: rx_valid=0, rx_data=0, rx_last=0, pkt_cnt=0, frag_err=0, ovf_err=0; FSM=IDLE,
//   bit counter=0, shift register=0, FIFO empty. Reset mid-packet discards partial state.
// Bit accept: a bit is accepted on any cycle with valido_n==0; cycles with valido_n==1
//   (gaps, padding) are ignored regardless of frameo_n. Bit k of byte lands at bit k.
// End-of-packet: accepted bit with frameo_n==1. Packet with 1 bit is legal framing-wise.
// FSM states: IDLE, RECV, DROP.
//   IDLE -> RECV: accepted bit with frameo_n==0.
//   IDLE, accepted bit with frameo_n==1: treated as 1-bit packet (fragment rule below).
//   RECV -> IDLE: end-of-packet bit accepted and its byte written.
//   RECV -> DROP: byte completes while FIFO full and no pop that cycle; set ovf_err.
//   DROP -> IDLE: end-of-packet bit accepted; no write; pkt_cnt not incremented.
// Byte write: on the 8th accepted bit, {frameo_n, byte} written to FIFO the same edge;
//   rx_valid rises the next cycle when FIFO was empty (1-cycle bit-to-head latency).
// Fragment: end-of-packet on bit 1..7 of a byte -> write zero-extended partial byte with
//   last=1, set frag_err, increment pkt_cnt (still a packet), bit counter to 0.
// pkt_cnt increments on the edge that writes a byte with last=1 (complete or fragment).
// Full/empty: write allowed when FIFO full only if a pop occurs the same cycle.
//   Pop on empty is ignored; rx_data/rx_last hold last value when rx_valid==0.
// Simultaneous write+pop on empty FIFO: pop ignored, write lands, rx_valid=1 next cycle.
// Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
// Overflow into DROP: bytes of the remainder of that packet are discarded; previously
//   written bytes of that packet stay in FIFO without a last marker (consumer uses ovf_err).
// err_clr same cycle as a new error event: set wins.
// New packet bits arriving in IDLE the cycle after an end bit are accepted (no gap needed).
// TESTING
// 1) 1-byte packet bits of 8'hA5 LSB first, frameo_n high on bit 7 -> rx_data=8'hA5,
//    rx_last=1, rx_valid 1 cycle after bit 7, pkt_cnt=1, no errors.
// 2) 3-byte packet 8'h01,8'h80,8'hFF with valido_n gaps of 1-5 cycles -> bytes in order,
//    rx_last only on 8'hFF, pkt_cnt=1.
// 3) 11-bit packet (8'h3C then bits 1,0,1) -> 8'h3C last=0, 8'h05 last=1, frag_err=1;
//    err_clr pulse -> frag_err=0.
// 4) rx_ready=0, send 17 one-byte packets with FIFO_DEPTH=16 -> 16 held, ovf_err=1,
//    pkt_cnt=16; drain -> 16 bytes with rx_last=1, rx_valid drops after 16th pop.
// 5) FIFO full, rx_ready=1 on cycle the next byte completes -> no overflow, order kept.
// 6) reset_n low mid-byte of packet 2 -> all outputs at reset values; next clean packet
//    received correctly with pkt_cnt=1.

Source files
------------

// File: rtl/router_port_rx.sv
// Receive endpoint for one router output port: deserialises the LSB-first bit stream into bytes.
// Bytes are tagged with an end-of-packet flag and queued in a FWFT FIFO behind a valid/ready interface.
module router_port_rx #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             dout,
   input  logic             valido_n,
   input  logic             frameo_n,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_last,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic             frag_err,
   output logic             ovf_err,
   input  logic             err_clr
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   state_t        state, state_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shreg, shreg_nxt, byte_val;
   logic          acc, byte_done, wr_ok, wr_en, pop, full;
   logic          frag_set, ovf_set;

   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic [8:0]    hold;

   assign acc      = ~valido_n;
   assign byte_val = shreg | ({7'b0, dout} << bit_cnt);
   assign full     = (count == (AW+1)'(FIFO_DEPTH));
   assign rx_valid = (count != '0);
   assign pop      = rx_valid & rx_ready;
   assign wr_ok    = ~full | pop;
   assign wr_en    = byte_done & wr_ok;

   // rx_data/rx_last show the last popped entry while the FIFO is empty
   assign rx_data  = rx_valid ? mem[rptr][7:0] : hold[7:0];
   assign rx_last  = rx_valid ? mem[rptr][8]   : hold[8];

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      byte_done   = 1'b0;
      frag_set    = 1'b0;
      ovf_set     = 1'b0;
      if (acc) begin
         case (state)
            IDLE, RECV: begin
               byte_done = (bit_cnt == 3'd7) | frameo_n;
               frag_set  = frameo_n & (bit_cnt != 3'd7);
               if (byte_done) begin
                  bit_cnt_nxt = '0;
                  shreg_nxt   = '0;
                  ovf_set     = ~wr_ok;
                  if (frameo_n)    state_nxt = IDLE;
                  else if (!wr_ok) state_nxt = DROP;
                  else             state_nxt = RECV;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  shreg_nxt   = byte_val;
                  state_nxt   = RECV;
               end
            end
            DROP: begin
               bit_cnt_nxt = '0;
               shreg_nxt   = '0;
               if (frameo_n) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         pkt_cnt  <= '0;
         frag_err <= 1'b0;
         ovf_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shreg    <= shreg_nxt;
         if (wr_en && frameo_n) pkt_cnt <= pkt_cnt + 1'b1;
         frag_err <= frag_set | (frag_err & ~err_clr);
         ovf_err  <= ovf_set  | (ovf_err  & ~err_clr);
      end
   end

   // Storage is left unreset; count==0 guarantees nothing stale is ever presented
   always_ff @(posedge clock) begin
      if (wr_en) mem[wptr] <= {frameo_n, byte_val};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         hold  <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (pop) begin
            rptr <= rptr + 1'b1;
            hold <= mem[rptr];
         end
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
